// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler.
// Holds the FSM encodings, default sizes and a pointer-width helper.
package tick_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int BURST_DEF = 3;
  localparam int CW_DEF    = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ARB     = 2'd1;
  localparam state_t ST_SERVE   = 2'd2;
  localparam state_t ST_RELEASE = 2'd3;

  // A single requester still needs a 1-bit index.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first req bit at or after ptr, wrapping.
// Ports: req, ptr in; one-hot win and its index win_idx out.
module rr_pick
  import tick_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PW   = ptr_w(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx
);

  always_comb begin
    logic found;
    int   j;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        win[j]  = 1'b1;
        win_idx = PW'(j);
      end
    end
  end

endmodule

// File: rtl/tick_scheduler.sv
// Shares the five-counter tick among NREQ requesters in BURST-tick grants.
// Ports: clock, reset (async, active-low), tick, req in; grant, tick_out,
// ctr_clear, done, busy out. TICK_SCHED_FIXED_PRIO_EN selects fixed
// lowest-index priority instead of round-robin.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int BURST = BURST_DEF,
  parameter int CW    = CW_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tick,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] tick_out,
  output logic            ctr_clear,
  output logic [NREQ-1:0] done,
  output logic            busy
);

  localparam int            PW   = ptr_w(NREQ);
  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            clr_q, clr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] win;
  logic            req_hit;

`ifdef TICK_SCHED_FIXED_PRIO_EN
  // Scan high to low so the lowest requesting bit wins.
  always_comb begin
    win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end
`else
  localparam logic [PW-1:0] IDX_MAX = PW'(NREQ - 1);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [PW-1:0] win_idx;

  rr_pick #(
    .NREQ(NREQ),
    .PW  (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .win    (win),
    .win_idx(win_idx)
  );

  always_comb begin
    idx_d = idx_q;
    ptr_d = ptr_q;
    if (state_q == ST_ARB && |req) idx_d = win_idx;
    if (state_q == ST_RELEASE) begin
      ptr_d = (idx_q == IDX_MAX) ? '0 : idx_q + PW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      idx_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      idx_q <= idx_d;
    end
  end
`endif

  assign req_hit = |(req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    clr_d   = 1'b0;
    done_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (|req) begin
          grant_d = win;
          cnt_d   = '0;
          clr_d   = 1'b1;
          state_d = ST_SERVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVE: begin
        // Abort wins over a same-cycle tick; that tick is
        // still forwarded combinationally but ends nothing.
        if (!req_hit) begin
          grant_d = '0;
          state_d = ST_RELEASE;
        end else if (tick) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            done_d  = grant_q;
            grant_d = '0;
            state_d = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        grant_d = '0;
        state_d = (|req) ? ST_ARB : ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      cnt_q   <= '0;
      clr_q   <= 1'b0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign ctr_clear = clr_q;
  assign busy      = (state_q != ST_IDLE);
  assign tick_out  = (state_q == ST_SERVE) ?
                     (grant_q & {NREQ{tick}}) : '0;

endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler (NREQ=4, BURST=3).
// Table vectors, directed sequences and a random run against a model.
module tb_tick_scheduler;

  localparam int NREQ  = 4;
  localparam int BURST = 3;

  logic       clock;
  logic       reset = 1'b1;
  logic       tick  = 1'b0;
  logic [3:0] req   = 4'b0;
  logic [3:0] grant, tick_out, done;
  logic       ctr_clear, busy;

  tick_scheduler #(
    .NREQ (NREQ),
    .BURST(BURST),
    .CW   (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .req      (req),
    .grant    (grant),
    .tick_out (tick_out),
    .ctr_clear(ctr_clear),
    .done     (done),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: the scheduler's phase, who holds the stream,
  // how many ticks they have received and where the scan starts.
  int m_st, m_g, m_cnt, m_ptr;
  bit m_clr, m_done;
  int fc;

  int         tout_tot, tout_burst;
  logic [3:0] prev_g;
  logic [3:0] gq[$];
  int         bq[$];

  typedef struct {
    logic [3:0] req;
    logic       tick;
    logic [3:0] tout;
    logic [3:0] gnt;
    logic       clr;
    logic [3:0] dn;
    logic       bsy;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    int base;
    base = 0;
`ifndef TICK_SCHED_FIXED_PRIO_EN
    base = m_ptr;
`endif
    for (int k = 0; k < NREQ; k++)
      if (r[(base + k) % NREQ]) return (base + k) % NREQ;
    return 0;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic t);
    m_clr  = 0;
    m_done = 0;
    case (m_st)
      0: if (r != 0) m_st = 1;
      1: begin
        if (r == 0) m_st = 0;
        else begin
          m_g = pick(r); m_cnt = 0; m_clr = 1; m_st = 2;
        end
      end
      2: begin
        if (!r[m_g]) m_st = 3;
        else if (t) begin
          m_cnt++;
          if (m_cnt == BURST) begin m_done = 1; m_st = 3; end
        end
      end
      default: begin
`ifndef TICK_SCHED_FIXED_PRIO_EN
        m_ptr = (m_g + 1) % NREQ;
`endif
        m_st = (r != 0) ? 1 : 0;
      end
    endcase
  endtask

  task automatic cycle(input logic [3:0] r, input logic t);
    logic [3:0] eto, eg, ed;
    bit pclr;
    req  = r;
    tick = t;
    eto  = (m_st == 2 && t) ? 4'(1 << m_g) : 4'b0;
    #1;
    chk("tick_out", {4'b0, tick_out}, {4'b0, eto});
    if (tick_out != 0) begin tout_tot++; tout_burst++; end
    pclr = m_clr;
    @(posedge clock);
    model_step(r, t);
    fc = pclr ? 0 : (fc + 1) % 5;
    #1;
    eg = (m_st == 2) ? 4'(1 << m_g) : 4'b0;
    ed = m_done ? 4'(1 << m_g) : 4'b0;
    chk("grant", {4'b0, grant}, {4'b0, eg});
    chk("done", {4'b0, done}, {4'b0, ed});
    chk("ctr_clear", {7'b0, ctr_clear}, {7'b0, m_clr});
    chk("busy", {7'b0, busy}, {7'b0, m_st != 0});
    if (grant != 0 && prev_g == 0) begin
      gq.push_back(grant);
      tout_burst = 0;
    end
    if (done != 0) bq.push_back(tout_burst);
    prev_g = grant;
  endtask

  task automatic fcycle(input logic [3:0] r);
    cycle(r, fc == 4);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick  = 1'b1;
    #1;
    chk("rst_grant", {4'b0, grant}, 8'h0);
    chk("rst_tick_out", {4'b0, tick_out}, 8'h0);
    chk("rst_done", {4'b0, done}, 8'h0);
    chk("rst_busy", {7'b0, busy}, 8'h0);
    chk("rst_clr", {7'b0, ctr_clear}, 8'h0);
    m_st = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
    m_clr = 0; m_done = 0; fc = 0;
    prev_g = 0; tout_tot = 0; tout_burst = 0;
    gq.delete(); bq.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    tick  = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] e3[5];
    int n;

    // IDLE -> ARB (tick dropped there) -> SERVE with 3 ticks -> RELEASE
    tbl[0] = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1};
    tbl[1] = '{4'b0100, 1'b1, 4'b0000, 4'b0100, 1'b1, 4'b0000, 1'b1};
    tbl[2] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[3] = '{4'b0100, 1'b0, 4'b0000, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[4] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[5] = '{4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1};
    tbl[6] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};

    #3;
    // 1: idle after reset
    do_reset();
    repeat (10) cycle(4'b0000, 1'b0);

    // table vectors, including a tick during ARB
    do_reset();
    for (int i = 0; i < 8; i++) begin
      req  = tbl[i].req;
      tick = tbl[i].tick;
      #1;
      chk($sformatf("tbl%0d_tout", i), {4'b0, tick_out}, {4'b0, tbl[i].tout});
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_gnt", i), {4'b0, grant}, {4'b0, tbl[i].gnt});
      chk($sformatf("tbl%0d_clr", i), {7'b0, ctr_clear}, {7'b0, tbl[i].clr});
      chk($sformatf("tbl%0d_done", i), {4'b0, done}, {4'b0, tbl[i].dn});
      chk($sformatf("tbl%0d_busy", i), {7'b0, busy}, {7'b0, tbl[i].bsy});
    end

    // 2: single requester with five-counter ticks
    do_reset();
    n = 0;
    while (bq.size() == 0 && n < 40) begin fcycle(4'b0100); n++; end
    if (bq.size() == 0) chk("t2_timeout", 8'h0, 8'h1);
    else begin
      chk("t2_grant", {4'b0, gq[0]}, 8'h04);
      chk("t2_ticks", 8'(bq[0]), 8'd3);
    end
    cycle(4'b0000, 1'b0);
    chk("t2_grant_off", {4'b0, grant}, 8'h0);

    // 3: all requesting, rotation over five grants
    do_reset();
    n = 0;
    while (gq.size() < 5 && n < 200) begin fcycle(4'b1111); n++; end
`ifdef TICK_SCHED_FIXED_PRIO_EN
    e3 = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    e3 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    if (gq.size() < 5) chk("t3_timeout", 8'h0, 8'h1);
    else begin
      for (int k = 0; k < 5; k++)
        chk($sformatf("t3_grant%0d", k), {4'b0, gq[k]}, {4'b0, e3[k]});
      for (int k = 0; k < 4; k++)
        chk($sformatf("t3_ticks%0d", k), 8'(bq[k]), 8'd3);
    end

    // 4: abort after the first tick, then two requesters
    do_reset();
    n = 0;
    while (tout_tot == 0 && n < 30) begin fcycle(4'b0010); n++; end
    if (tout_tot == 0) chk("t4_timeout", 8'h0, 8'h1);
    fcycle(4'b0000);
    chk("t4_grant_off", {4'b0, grant}, 8'h0);
    chk("t4_no_done", {4'b0, done}, 8'h0);
    chk("t4_no_burst", 8'(bq.size()), 8'h0);
    gq.delete();
    n = 0;
    while (gq.size() < 2 && n < 80) begin fcycle(4'b0011); n++; end
    if (gq.size() < 2) chk("t4_timeout2", 8'h0, 8'h1);
    else begin
      chk("t4_first", {4'b0, gq[0]}, 8'h01);
`ifdef TICK_SCHED_FIXED_PRIO_EN
      chk("t4_second", {4'b0, gq[1]}, 8'h01);
`else
      chk("t4_second", {4'b0, gq[1]}, 8'h02);
`endif
    end

    // 5: reset in the middle of a burst on requester 3
    do_reset();
    n = 0;
    while (tout_tot < 2 && n < 40) begin fcycle(4'b1000); n++; end
    if (tout_tot < 2) chk("t5_timeout", 8'h0, 8'h1);
    chk("t5_busy_before", {7'b0, busy}, 8'h1);
    do_reset();
    n = 0;
    while (gq.size() < 1 && n < 10) begin fcycle(4'b1001); n++; end
    if (gq.size() < 1) chk("t5_timeout2", 8'h0, 8'h1);
    else chk("t5_grant", {4'b0, gq[0]}, 8'h01);

    // random run against the model
    do_reset();
    r = 4'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      if (i < 750) fcycle(r);
      else cycle(r, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
